// File: rtl/ldl_sfifo_fwft.sv
// ldl_sfifo_fwft: single-clock FIFO with fall-through or registered read,
// programmable almost flags and sticky overflow/underflow error flags.
module ldl_sfifo_fwft #(
   parameter int DWIDTH   = 8,
   parameter int AWIDTH   = 4,
   parameter int FWFT     = 1,
   parameter int AF_LEVEL = (2 ** AWIDTH) - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [DWIDTH-1:0] din,
   input  logic              re,
   output logic [DWIDTH-1:0] dout,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [AWIDTH:0]   count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
);

   localparam int DEPTH = 2 ** AWIDTH;

   localparam logic [AWIDTH:0] DEPTH_C = DEPTH[AWIDTH:0];
   localparam logic [AWIDTH:0] AF_C    = AF_LEVEL[AWIDTH:0];
   localparam logic [AWIDTH:0] AE_C    = AE_LEVEL[AWIDTH:0];
   localparam logic [AWIDTH:0] TWO_C   = (AWIDTH + 1)'(2);

   logic [DWIDTH-1:0] mem_q [DEPTH];

   logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [AWIDTH-1:0] rd_next;
   logic [AWIDTH:0]   count_q, count_d;
   logic [DWIDTH-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              af_q, af_d;
   logic              ae_q, ae_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              wr_ok;
   logic              rd_ok;

   assign wr_ok   = we & ~full_q;
   assign rd_ok   = re & ~empty_q;
   assign rd_next = rd_ptr_q + 1'b1;

   // Pointer and occupancy bookkeeping, shared by both read modes.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
         rd_ptr_d = rd_next;
      end
      unique case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Output register load: read-ahead prefetch or registered pop.
   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      empty_d = empty_q;
      if (FWFT != 0) begin
         if (rd_ok) begin
            // Head leaves; the word behind it is already in memory when
            // count >= 2, so fetch it now to avoid a bubble.
            if (count_q >= TWO_C) begin
               dout_d  = mem_q[rd_next];
               valid_d = 1'b1;
            end else begin
               valid_d = 1'b0;
            end
         end else if (!valid_q && (count_q != '0)) begin
            dout_d  = mem_q[rd_ptr_q];
            valid_d = 1'b1;
         end
         empty_d = ~valid_d;
      end else begin
         if (rd_ok) begin
            dout_d = mem_q[rd_ptr_q];
         end
         valid_d = (count_d != '0);
         empty_d = (count_d == '0);
      end
   end

   // Level flags follow the post-edge count; error flags are sticky.
   always_comb begin
      full_d = (count_d == DEPTH_C);
      af_d   = (count_d >= AF_C);
      ae_d   = (count_d <= AE_C);
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      if (we & full_q) begin
         ovf_d = 1'b1;
      end else if (clr_err) begin
         ovf_d = 1'b0;
      end
      if (re & empty_q) begin
         unf_d = 1'b1;
      end else if (clr_err) begin
         unf_d = 1'b0;
      end
   end

   // Storage array: written on accepted writes, never reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Control and output state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign dout         = dout_q;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_ldl_sfifo_fwft.sv
// tb_ldl_sfifo_fwft: drives a fall-through and a standard-mode FIFO with
// directed and random traffic and checks both against a queue model.
module tb_ldl_sfifo_fwft;

   localparam int DW = 8;
   localparam int AW = 2;
   localparam int DEPTH = 4;
   localparam int AFL = 2;
   localparam int AEL = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic we = 1'b0;
   logic re = 1'b0;
   logic clr = 1'b0;
   logic [DW-1:0] din = '0;

   logic [DW-1:0] fw_dout, st_dout;
   logic fw_empty, fw_full, fw_af, fw_ae, fw_ovf, fw_unf;
   logic st_empty, st_full, st_af, st_ae, st_ovf, st_unf;
   logic [AW:0] fw_count, st_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ldl_sfifo_fwft #(
      .DWIDTH(DW), .AWIDTH(AW), .FWFT(1),
      .AF_LEVEL(AFL), .AE_LEVEL(AEL)
   ) u_fw (
      .clk(clk), .rst(rst), .we(we), .din(din), .re(re),
      .dout(fw_dout), .empty(fw_empty), .full(fw_full),
      .almost_full(fw_af), .almost_empty(fw_ae), .count(fw_count),
      .overflow(fw_ovf), .underflow(fw_unf), .clr_err(clr)
   );

   ldl_sfifo_fwft #(
      .DWIDTH(DW), .AWIDTH(AW), .FWFT(0),
      .AF_LEVEL(AFL), .AE_LEVEL(AEL)
   ) u_st (
      .clk(clk), .rst(rst), .we(we), .din(din), .re(re),
      .dout(st_dout), .empty(st_empty), .full(st_full),
      .almost_full(st_af), .almost_empty(st_ae), .count(st_count),
      .overflow(st_ovf), .underflow(st_unf), .clr_err(clr)
   );

   // Behavioural model: index 0 = standard mode, 1 = fall-through mode.
   logic [DW-1:0] mq0[$];
   logic [DW-1:0] mq1[$];
   bit            mv[2];
   logic [DW-1:0] md[2];
   bit            mo[2];
   bit            mu[2];
   bit            started = 0;

   function automatic int msize(input int m);
      return (m == 1) ? mq1.size() : mq0.size();
   endfunction

   function automatic bit mempty(input int m);
      if (m == 1) return !mv[1];
      return (mq0.size() == 0);
   endfunction

   task automatic step(input int m);
      logic [DW-1:0] q[$];
      int n;
      bit emp, fl, wok, rok;
      if (m == 1) q = mq1;
      else q = mq0;
      if (rst) begin
         q.delete();
         mv[m] = 0;
         md[m] = '0;
         mo[m] = 0;
         mu[m] = 0;
      end else begin
         n = q.size();
         emp = mempty(m);
         fl = (n == DEPTH);
         wok = we && !fl;
         rok = re && !emp;
         if (we && fl) mo[m] = 1;
         else if (clr) mo[m] = 0;
         if (re && emp) mu[m] = 1;
         else if (clr) mu[m] = 0;
         if (m == 1) begin
            if (rok) begin
               if (n >= 2) begin
                  md[m] = q[1];
                  mv[m] = 1;
               end else begin
                  mv[m] = 0;
               end
            end else if (!mv[m] && n >= 1) begin
               md[m] = q[0];
               mv[m] = 1;
            end
         end else if (rok) begin
            md[m] = q[0];
         end
         if (rok) void'(q.pop_front());
         if (wok) q.push_back(din);
      end
      if (m == 1) mq1 = q;
      else mq0 = q;
   endtask

   always @(posedge clk) begin
      step(0);
      step(1);
      if (rst) started = 1;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both DUTs against the model.
   always @(negedge clk) begin
      if (started) begin
         chk("fw_dout", fw_dout, md[1]);
         chk("fw_empty", fw_empty, mempty(1));
         chk("fw_count", fw_count, msize(1));
         chk("fw_full", fw_full, msize(1) == DEPTH);
         chk("fw_af", fw_af, msize(1) >= AFL);
         chk("fw_ae", fw_ae, msize(1) <= AEL);
         chk("fw_ovf", fw_ovf, mo[1]);
         chk("fw_unf", fw_unf, mu[1]);
         chk("st_dout", st_dout, md[0]);
         chk("st_empty", st_empty, mempty(0));
         chk("st_count", st_count, msize(0));
         chk("st_full", st_full, msize(0) == DEPTH);
         chk("st_af", st_af, msize(0) >= AFL);
         chk("st_ae", st_ae, msize(0) <= AEL);
         chk("st_ovf", st_ovf, mo[0]);
         chk("st_unf", st_unf, mu[0]);
      end
   end

   task automatic cyc(input bit w, input logic [DW-1:0] d,
                      input bit r, input bit c, input bit rs);
      we = w;
      din = d;
      re = r;
      clr = c;
      rst = rs;
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset state
      cyc(0, 8'h00, 0, 0, 1);
      chk("lit_rst_count", fw_count, 0);
      chk("lit_rst_empty", fw_empty, 1);
      chk("lit_rst_ae", fw_ae, 1);
      chk("lit_rst_dout", fw_dout, 0);

      // Fall-through latency of first word
      cyc(1, 8'hA1, 0, 0, 0);
      chk("lit_fw_cnt1", fw_count, 1);
      chk("lit_fw_emp1", fw_empty, 1);
      cyc(0, 8'h00, 0, 0, 0);
      chk("lit_fw_emp2", fw_empty, 0);
      chk("lit_fw_dout2", fw_dout, 8'hA1);
      chk("lit_fw_ovf2", fw_ovf, 0);
      chk("lit_fw_unf2", fw_unf, 0);

      // Fill, overflow, full with read, clear
      cyc(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 0);
      chk("lit_full", fw_full, 1);
      chk("lit_af", fw_af, 1);
      cyc(1, 8'hEE, 0, 0, 0);
      chk("lit_ovf", fw_ovf, 1);
      chk("lit_ovf_cnt", fw_count, 4);
      cyc(1, 8'hEF, 1, 0, 0);
      chk("lit_fr_cnt", fw_count, 3);
      chk("lit_fr_dout", fw_dout, 8'h11);
      chk("lit_fr_ovf", fw_ovf, 1);
      chk("lit_st_fr_dout", st_dout, 8'h10);
      cyc(0, 8'h00, 0, 1, 0);
      chk("lit_clr_ovf", fw_ovf, 0);

      // Back-to-back reads, drain, underflow
      cyc(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 0);
      chk("lit_b2b_d0", fw_dout, 8'h10);
      for (int i = 1; i < 4; i++) begin
         cyc(0, 8'h00, 1, 0, 0);
         chk("lit_b2b_d", fw_dout, 8'h10 + i);
         chk("lit_b2b_e", fw_empty, 0);
      end
      cyc(0, 8'h00, 1, 0, 0);
      chk("lit_drain_e", fw_empty, 1);
      chk("lit_drain_ae", fw_ae, 1);
      chk("lit_st_drain", st_dout, 8'h13);
      cyc(0, 8'h00, 1, 0, 0);
      chk("lit_unf", fw_unf, 1);
      chk("lit_unf_dout", fw_dout, 8'h13);

      // Standard-mode registered read
      cyc(0, 8'h00, 0, 0, 1);
      cyc(1, 8'h55, 0, 0, 0);
      cyc(1, 8'h66, 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 0);
      chk("lit_st_d55", st_dout, 8'h55);
      chk("lit_st_c1", st_count, 1);
      cyc(1, 8'h77, 1, 0, 0);
      chk("lit_st_d66", st_dout, 8'h66);
      chk("lit_st_c1b", st_count, 1);

      // Pointer wrap with interleaved traffic
      cyc(0, 8'h00, 0, 0, 1);
      for (int rep = 0; rep < 3; rep++) begin
         for (int i = 0; i < 6; i++)
            cyc(1, 8'(rep * 16 + i), i >= 3, 0, 0);
         for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1, 0, 0);
      end

      // Reset mid-stream clears contents and flags
      cyc(0, 8'h00, 0, 0, 1);
      cyc(0, 8'h00, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 8'hC0 + 8'(i), 0, 0, 0);
      chk("lit_mid_cnt", fw_count, 3);
      chk("lit_mid_unf", fw_unf, 1);
      cyc(1, 8'hCC, 1, 0, 1);
      chk("lit_rst2_cnt", fw_count, 0);
      chk("lit_rst2_emp", fw_empty, 1);
      chk("lit_rst2_full", fw_full, 0);
      chk("lit_rst2_unf", fw_unf, 0);
      chk("lit_rst2_scnt", st_count, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 9) < 6,
             8'($urandom),
             $urandom_range(0, 9) < 5,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 199) == 0);
      end
      cyc(0, 8'h00, 0, 0, 0);
      @(negedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
